// File: rtl/fader_pkg.sv
// Shared types and reset-phase helpers for the multi-channel PWM fader.
package fader_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_SAW     = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Position of channel i on the 2*STEPS-long triangle, spread evenly across channels
  function automatic int unsigned init_phase(int unsigned i, int unsigned num_ch,
                                             int unsigned steps);
    return (i * 2 * steps) / num_ch;
  endfunction

  function automatic int unsigned init_level(int unsigned i, int unsigned num_ch,
                                             int unsigned steps, int unsigned step);
    int unsigned k;
    k = init_phase(i, num_ch, steps);
    if (k < steps)       return k * step;
    else if (k == steps) return steps * step;
    else                 return (2 * steps - k) * step;
  endfunction

  function automatic dir_t init_dir(int unsigned i, int unsigned num_ch, int unsigned steps);
    return (init_phase(i, num_ch, steps) < steps) ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One fader channel: level/direction sequencer, period-aligned duty shadow
// and the registered PWM pin.
module fade_channel
  import fader_pkg::*;
#(
  parameter int unsigned PWM_INTERVAL = 1200,
  parameter int unsigned STEP         = 6,
  parameter int unsigned LW           = 11,
  parameter int unsigned CW           = 11,
  parameter int unsigned INIT_LEVEL   = 0,
  parameter dir_t        INIT_DIR     = DIR_UP,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_tick,
  input  logic          pwm_wrap,
  input  logic [CW-1:0] pwm_cnt,
  input  mode_t         mode,
  output logic          pwm_out
);

  localparam logic [LW:0]   MAX_X  = (LW+1)'(PWM_INTERVAL);
  localparam logic [LW:0]   STEP_X = (LW+1)'(STEP);
  localparam logic [LW-1:0] MAX_L  = LW'(PWM_INTERVAL);

  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic [LW-1:0] duty;
  dir_t          dir;
  dir_t          dir_nxt;
  logic [LW:0]   level_x;
  logic [LW:0]   sum_x;

  always_ff @(posedge clk) begin
    if (reset) begin
      level <= LW'(INIT_LEVEL);
      dir   <= INIT_DIR;
    end else begin
      level <= level_nxt;
      dir   <= dir_nxt;
    end
  end

  // Level sequencing; one extra bit keeps level+STEP from wrapping
  always_comb begin
    level_nxt = level;
    dir_nxt   = dir;
    level_x   = {1'b0, level};
    sum_x     = level_x + STEP_X;
    case (mode)
      MODE_OFF: begin
        level_nxt = '0;
        dir_nxt   = DIR_UP;
      end
      MODE_ON: begin
        level_nxt = MAX_L;
        dir_nxt   = DIR_DOWN;
      end
      MODE_BREATHE: begin
        if (step_tick) begin
          if (dir == DIR_UP) begin
            if (sum_x >= MAX_X) begin
              level_nxt = MAX_L;
              dir_nxt   = DIR_DOWN;
            end else begin
              level_nxt = sum_x[LW-1:0];
            end
          end else begin
            if (level_x <= STEP_X) begin
              level_nxt = '0;
              dir_nxt   = DIR_UP;
            end else begin
              level_nxt = LW'(level_x - STEP_X);
            end
          end
        end
      end
      MODE_SAW: begin
        if (step_tick) begin
          dir_nxt = DIR_UP;
          if (level_x == MAX_X)     level_nxt = '0;
          else if (sum_x >= MAX_X)  level_nxt = MAX_L;
          else                      level_nxt = sum_x[LW-1:0];
        end
      end
      default: begin
        level_nxt = level;
        dir_nxt   = dir;
      end
    endcase
  end

  // Duty only moves at the period boundary so a period is never cut short
  always_ff @(posedge clk) begin
    if (reset) begin
      duty    <= LW'(INIT_LEVEL);
      pwm_out <= ACTIVE_LOW;
    end else begin
      if (pwm_wrap) duty <= level;
      pwm_out <= (LW'(pwm_cnt) < duty) ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/multi_pwm_fader.sv
// N-channel PWM LED fader: shared PWM and step counters feeding one
// fade_channel per output pin.
module multi_pwm_fader
  import fader_pkg::*;
#(
  parameter int unsigned NUM_CH        = 3,
  parameter int unsigned PWM_INTERVAL  = 1200,
  parameter int unsigned STEPS         = 200,
  parameter int unsigned STEP_INTERVAL = 12000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*NUM_CH-1:0]   mode,
  input  logic                  pause,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  step_tick
);

  localparam int unsigned STEP = PWM_INTERVAL / STEPS;
  localparam int unsigned LW   = $clog2(PWM_INTERVAL + 1);
  localparam int unsigned CW   = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
  localparam int unsigned SW   = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;

  localparam logic [CW-1:0] PWM_LAST  = CW'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_INTERVAL - 1);

  logic [CW-1:0] pwm_cnt;
  logic [SW-1:0] step_cnt;
  logic          pwm_wrap;

  assign pwm_wrap  = (pwm_cnt == PWM_LAST);
  assign step_tick = (step_cnt == STEP_LAST) && !pause && !reset;

  // PWM period counter is free-running; pause does not stop the waveform
  always_ff @(posedge clk) begin
    if (reset)         pwm_cnt <= '0;
    else if (pwm_wrap) pwm_cnt <= '0;
    else               pwm_cnt <= pwm_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt <= '0;
    end else if (!pause) begin
      if (step_cnt == STEP_LAST) step_cnt <= '0;
      else                       step_cnt <= step_cnt + SW'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fade_channel #(
      .PWM_INTERVAL (PWM_INTERVAL),
      .STEP         (STEP),
      .LW           (LW),
      .CW           (CW),
      .INIT_LEVEL   (init_level(i, NUM_CH, STEPS, STEP)),
      .INIT_DIR     (init_dir(i, NUM_CH, STEPS)),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .step_tick (step_tick),
      .pwm_wrap  (pwm_wrap),
      .pwm_cnt   (pwm_cnt),
      .mode      (mode_t'(mode[2*i +: 2])),
      .pwm_out   (pwm_out[i])
    );
  end

endmodule
